// File: rtl/serial_word_rx_pkg.sv
// Shared types and helpers for the serial word receiver: FSM state encoding,
// tick counter sizing and the even-parity helper.
package serial_word_rx_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    PARITY
  } state_t;

  localparam int TICK_W_MIN = 1;

  // A counter that holds 0..clks_per_bit-1 needs $clog2 bits, but never less than one.
  function automatic int tick_cnt_width(input int clks_per_bit);
    int w;
    w = $clog2(clks_per_bit);
    return (w < TICK_W_MIN) ? TICK_W_MIN : w;
  endfunction

  // Returns the bit that would make v even parity.
  function automatic logic even_parity(input logic [31:0] v);
    return ^v;
  endfunction

endpackage

// File: rtl/serial_word_rx_bit_tick_gen.sv
// Reloadable bit-period down-counter; tick is high whenever the count is 0.
// restart reloads CLKS_PER_BIT-1, so the first tick lands CLKS_PER_BIT edges later.
module bit_tick_gen
  import serial_word_rx_pkg::*;
#(
  parameter int CLKS_PER_BIT = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic restart,
  output logic tick
);

  localparam int TICK_W = tick_cnt_width(CLKS_PER_BIT);
  localparam logic [TICK_W-1:0] RELOAD = TICK_W'(CLKS_PER_BIT - 1);

  logic [TICK_W-1:0] cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (restart || cnt == '0) begin
      cnt <= RELOAD;
    end else begin
      cnt <= cnt - TICK_W'(1);
    end
  end

  assign tick = (cnt == '0);

endmodule

// File: rtl/serial_word_rx.sv
// Start-triggered MSB-first serial word receiver with valid/ack output register and overrun pulse.
// Optional trailing even-parity bit when SERIAL_WORD_RX_PARITY_EN is defined.
module serial_word_rx
  import serial_word_rx_pkg::*;
#(
  parameter int WIDTH        = 4,
  parameter int CLKS_PER_BIT = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             serial_in,
  input  logic             data_ack,
  output logic [WIDTH-1:0] data,
  output logic             data_valid,
  output logic             busy,
  output logic             overrun,
  output logic             parity_err
);

  localparam int CW = $clog2(WIDTH + 1);

  state_t           state;
  logic [WIDTH-1:0] shift;
  logic [WIDTH-1:0] shift_nxt;
  logic [WIDTH-1:0] commit_word;
  logic [CW-1:0]    bit_cnt;
  logic             tick;
  logic             last_bit;
  logic             commit;
  logic             commit_perr;

  bit_tick_gen #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_tick (
    .clk     (clk),
    .reset   (reset),
    .restart (start),
    .tick    (tick)
  );

  // Shift register is cleared at start, so each sample only has to OR in its bit.
  assign shift_nxt = shift | (WIDTH'(serial_in) << (bit_cnt - CW'(1)));
  assign last_bit  = (state == SHIFT) && tick && (bit_cnt == CW'(1));

`ifdef SERIAL_WORD_RX_PARITY_EN
  assign commit      = (state == PARITY) && tick;
  assign commit_word = shift;
  assign commit_perr = even_parity(32'(shift)) ^ serial_in;
`else
  assign commit      = last_bit;
  assign commit_word = shift_nxt;
  assign commit_perr = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      shift      <= '0;
      bit_cnt    <= '0;
      data       <= '0;
      data_valid <= 1'b0;
      busy       <= 1'b0;
      overrun    <= 1'b0;
      parity_err <= 1'b0;
    end else begin
      overrun <= 1'b0;

      // Output register: a commit wins over an ack; an ack in the commit cycle consumes the old word.
      if (commit) begin
        data       <= commit_word;
        data_valid <= 1'b1;
        parity_err <= commit_perr;
        overrun    <= data_valid && !data_ack;
      end else if (data_ack && data_valid) begin
        data_valid <= 1'b0;
        parity_err <= 1'b0;
      end

      // start always (re)begins a word; a coinciding commit above still completes.
      if (start) begin
        state   <= SHIFT;
        shift   <= '0;
        bit_cnt <= CW'(WIDTH);
        busy    <= 1'b1;
      end else begin
        case (state)
          SHIFT: begin
            if (tick) begin
              shift   <= shift_nxt;
              bit_cnt <= bit_cnt - CW'(1);
              if (last_bit) begin
`ifdef SERIAL_WORD_RX_PARITY_EN
                state <= PARITY;
`else
                state <= IDLE;
                busy  <= 1'b0;
`endif
              end
            end
          end
          PARITY: begin
            if (tick) begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_serial_word_rx.sv
// Scoreboard bench for serial_word_rx: default-parameter instance under random traffic,
// plus a WIDTH=8 / CLKS_PER_BIT=4 instance for bit-period timing.
module tb_serial_word_rx;

`ifdef SERIAL_WORD_RX_PARITY_EN
  localparam int P = 1;
`else
  localparam int P = 0;
`endif
  localparam int W      = 4;
  localparam int CPB    = 1;
  localparam int NB     = W + P;
  localparam int W_B    = 8;
  localparam int CPB_B  = 4;
  localparam int NB_B   = W_B + P;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic start = 1'b0, serial_in = 1'b0, data_ack = 1'b0;
  logic [W-1:0] data;
  logic data_valid, busy, overrun, parity_err;

  logic b_start = 1'b0, b_serial = 1'b0, b_ack = 1'b0;
  logic [W_B-1:0] b_data;
  logic b_valid, b_busy, b_ovr, b_perr;

  serial_word_rx #(.WIDTH(W), .CLKS_PER_BIT(CPB)) dut (
    .clk(clk), .reset(reset), .start(start), .serial_in(serial_in), .data_ack(data_ack),
    .data(data), .data_valid(data_valid), .busy(busy), .overrun(overrun), .parity_err(parity_err)
  );

  serial_word_rx #(.WIDTH(W_B), .CLKS_PER_BIT(CPB_B)) dut_b (
    .clk(clk), .reset(reset), .start(b_start), .serial_in(b_serial), .data_ack(b_ack),
    .data(b_data), .data_valid(b_valid), .busy(b_busy), .overrun(b_ovr), .parity_err(b_perr)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         cyc;
    bit         is_commit;
    logic [W-1:0] word;
    bit         perr;
    bit         ovr;
    bit         busy;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int n_cmp = 0;
  int n_bad = 0;
  bit mvalid = 1'b0;
  bit pend = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", nm, cyc, act, expv);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Monitor: checks whatever the stimulus scheduled for this cycle, else that overrun is quiet.
  always @(negedge clk) begin
    if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
      mon_e = exp_q.pop_front();
      if (mon_e.is_commit) begin
        chk("commit_data", data, mon_e.word);
        chk("commit_valid", data_valid, 1);
        chk("commit_overrun", overrun, mon_e.ovr);
        chk("commit_parity_err", parity_err, mon_e.perr);
        chk("commit_busy", busy, mon_e.busy);
      end else begin
        chk("ack_valid_clear", data_valid, 0);
        chk("ack_parity_clear", parity_err, 0);
        chk("ack_overrun", overrun, 0);
      end
    end else begin
      chk("idle_overrun", overrun, 0);
    end
  end

  // Idle cycles; ack_mode 0 = never, 1 = always, 2 = random.
  task automatic gap(input int n, input int ack_mode);
    bit a;
    for (int i = 0; i < n; i++) begin
      a = (ack_mode == 1) || (ack_mode == 2 && ($urandom % 3 == 0));
      data_ack = a;
      step();
      if (a) begin
        mvalid = 1'b0;
        exp_q.push_back('{cyc: cyc, is_commit: 1'b0, word: '0, perr: 1'b0, ovr: 1'b0, busy: 1'b0});
      end
    end
    data_ack = 1'b0;
  endtask

  // One word: optional aborted prefix, then NB bits; start for the next word may ride on the commit edge.
  task automatic send(input logic [W-1:0] w, input bit pb, input int abort_j,
                      input logic [W-1:0] w_abort, input bit nb2b, input bit ack_c);
    exp_t e;
    if (!pend) begin
      start = 1'b1;
      step();
    end
    start = 1'b0;
    if (abort_j > 0) begin
      for (int k = 0; k < abort_j; k++) begin
        serial_in = w_abort[W-1-k];
        for (int c = 0; c < CPB; c++) step();
      end
      start = 1'b1;
      step();
      start = 1'b0;
    end
    for (int k = 0; k < NB; k++) begin
      serial_in = (k < W) ? w[W-1-k] : pb;
      for (int c = 0; c < CPB; c++) begin
        if (k == NB - 1 && c == CPB - 1) begin
          start    = nb2b;
          data_ack = ack_c;
        end
        step();
        if (k == 0 && c == 0) chk("busy_mid_word", busy, 1);
      end
    end
    e.cyc       = cyc;
    e.is_commit = 1'b1;
    e.word      = w;
    e.perr      = (P == 1) ? (^{w, pb}) : 1'b0;
    e.ovr       = mvalid && !ack_c;
    e.busy      = nb2b;
    exp_q.push_back(e);
    mvalid   = 1'b1;
    data_ack = 1'b0;
    start    = 1'b0;
    pend     = nb2b;
  endtask

  task automatic run_words(input int n);
    logic [W-1:0] w, wa;
    int ab;
    bit b2b;
    for (int i = 0; i < n; i++) begin
      if (!pend) gap($urandom_range(0, 3), 2);
      w   = W'($urandom);
      wa  = W'($urandom);
      ab  = ($urandom % 4 == 0) ? $urandom_range(1, NB - 2) : 0;
      b2b = (i < n - 1) && ($urandom % 3 == 0);
      send(w, 1'($urandom), ab, wa, b2b, 1'($urandom));
    end
  endtask

  logic [NB_B-1:0] vb;
  int kb;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    step();
    step();
    chk("reset_data", data, 0);
    chk("reset_valid", data_valid, 0);
    chk("reset_busy", busy, 0);
    chk("reset_overrun", overrun, 0);
    chk("reset_parity_err", parity_err, 0);
    reset = 1'b0;
    step();

    // 1011 with both parity choices, then 3 and C back to back without ack, then an abort.
    send(4'b1011, 1'b0, 0, '0, 1'b0, 1'b0);
    gap(1, 1);
    send(4'b1011, 1'b1, 0, '0, 1'b0, 1'b0);
    gap(1, 1);
    send(4'h3, 1'b0, 0, '0, 1'b1, 1'b0);
    send(4'hC, 1'b0, 0, '0, 1'b0, 1'b0);
    gap(2, 0);
    send(4'h6, 1'b0, 2, 4'h9, 1'b0, 1'b1);
    gap(2, 0);

    // Reset in the middle of a word clears everything immediately.
    start = 1'b1;
    step();
    start = 1'b0;
    serial_in = 1'b1;
    step();
    step();
    reset = 1'b1;
    #1;
    chk("midreset_data", data, 0);
    chk("midreset_valid", data_valid, 0);
    chk("midreset_busy", busy, 0);
    chk("midreset_overrun", overrun, 0);
    chk("midreset_parity_err", parity_err, 0);
    mvalid = 1'b0;
    step();
    reset = 1'b0;
    step();
    send(4'h5, 1'b0, 0, '0, 1'b0, 1'b0);

    run_words(150);
    gap(3, 0);

    // Wide/slow instance: off-sample edges carry the wrong bit, so only every CPB_B-th edge may be used.
`ifdef SERIAL_WORD_RX_PARITY_EN
    vb = {8'hA5, 1'b0};
`else
    vb = 8'hA5;
`endif
    b_start = 1'b1;
    step();
    b_start = 1'b0;
    for (int e = 1; e <= NB_B * CPB_B; e++) begin
      kb = (e + CPB_B - 1) / CPB_B - 1;
      b_serial = (e % CPB_B == 0) ? vb[NB_B-1-kb] : ~vb[NB_B-1-kb];
      step();
      if (e == 1) chk("b_busy_mid", b_busy, 1);
      if (e == NB_B * CPB_B - 1) chk("b_valid_before_commit", b_valid, 0);
    end
    chk("b_data", b_data, 8'hA5);
    chk("b_valid", b_valid, 1);
    chk("b_busy_after", b_busy, 0);
    chk("b_overrun", b_ovr, 0);
    chk("b_parity_err", b_perr, 0);

    step();
    step();
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/serial_word_rx.md
# serial_word_rx

Parametrised successor to the 4-bit keyboard serial receiver. It waits for a one-cycle start pulse, then shifts in WIDTH bits from a single data line, MSB first, one bit every CLKS_PER_BIT clocks. The received word is held in an output register with a valid/ack handshake and overrun detection. It sits between the keyboard/serial front end and the message-decoding logic.

## Interface
- WIDTH, 4: data bits per word; legal range 1..32.
- CLKS_PER_BIT, 1: clock cycles per serial bit; legal range 1..256.
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  start-of-word pulse; sampled on each rising edge of clk.
- serial_in  in  1  serial data line.
- data_ack  in  1  consumer acknowledge; clears data_valid.
- data  out  WIDTH  last completed word; reset 0.
- data_valid  out  1  level; high while data holds an unacknowledged word; reset 0.
- busy  out  1  high while a word is being received; reset 0.
- overrun  out  1  one-cycle pulse when an unacknowledged word is overwritten; reset 0.
- parity_err  out  1  high with data_valid when the received parity is wrong; reset 0; tied 0 without the macro.

## Operation
- States:
  - IDLE → SHIFT on start.
  - SHIFT → PARITY after the last data bit, when the macro is defined.
  - SHIFT/PARITY → IDLE after the last sample, and the word is committed.
- Bit timing: a tick counter is loaded with CLKS_PER_BIT-1 on start and counts down; a sample is taken when it reaches 0, then it reloads.
- Bit counter: loaded with WIDTH and decremented per sample. Sample k (k = 0..WIDTH-1) writes shift bit WIDTH-1-k, so the word is MSB first.
- Commit: data ← shift register; data_valid ← 1; busy ← 0.
- If data_valid was already 1 at commit and data_ack is not high in that cycle, overrun pulses for 1 cycle and data is overwritten (newest word wins).
- data_ack with data_valid high clears data_valid on the next edge. data_ack with data_valid low is ignored.
- Simultaneous events:
  - Commit and data_ack in the same cycle: the ack consumes the old word. data_valid stays 1 for the new word, and there is no overrun.
  - start during SHIFT/PARITY: the current word is aborted with no commit and no overrun. Reception restarts with fresh counters; busy stays 1.
  - start in the commit cycle: the commit happens and reception restarts, so busy stays 1.
- Reset asserted mid-word: state goes to IDLE, all counters and outputs clear, and the partial word is discarded.

## Timing
- start is high at edge T.
- Sample k is taken at edge T + (k+1)·CLKS_PER_BIT.
- busy is high from after edge T until the commit edge.
- data/data_valid update at edge T + WIDTH·CLKS_PER_BIT. With parity, this is T + (WIDTH+1)·CLKS_PER_BIT.
- With the defaults, the word is visible 4 cycles after the start edge.
- data_valid falls at the edge that samples data_ack high.
- Minimum start-to-start spacing for back-to-back words equals the word length. Any closer spacing is an abort.

## Configuration
- SERIAL_WORD_RX_PARITY_EN defined:
  - One extra bit is sampled after the data bits in state PARITY.
  - Even parity over data plus the parity bit; a mismatch sets parity_err at commit.
  - parity_err is cleared with data_valid.
- Not defined:
  - There is no PARITY state.
  - parity_err is constant 0.

## Structure
- Package serial_word_rx_pkg holds:
  - the state enum (IDLE, SHIFT, PARITY);
  - a localparam for the tick counter width, $clog2(CLKS_PER_BIT) with a minimum of 1;
  - an even-parity function.
- One sub-module, bit_tick_gen: the reloadable CLKS_PER_BIT down-counter. It has clk, reset and a restart input, and outputs a one-cycle tick.

## Test plan
- Defaults, start at T, serial_in = 1,0,1,1 on samples 0..3. Required: data = 4'b1011 and data_valid high after T+4, busy low after T+4, overrun 0.
- WIDTH=8, CLKS_PER_BIT=4, byte 8'hA5 sent. Required: data = 8'hA5 at T+32, and sampling occurs only on every 4th edge.
- Two words 4'h3 then 4'hC back to back, no data_ack. Required: overrun pulses once at the second commit, data = 4'hC, data_valid stays 1.
- start re-pulsed after 2 bits. Required: no commit from the first word; the word that completes is the one sent after the second start.
- reset asserted during SHIFT. Required: all outputs 0 immediately, and the next start receives a clean word.
- Macro defined, 4'b1011 with parity bit 0. Required: parity_err = 1. With parity bit 1: parity_err = 0, and commit occurs at T+5.
